// File: rtl/instr_loader.sv
// Boot-time instruction loader: receives a 2-byte word-count header and a
// big-endian byte stream, writes 32-bit words into instruction memory from
// word 0 upward, and holds the CPU in reset until the program is in place.
module instr_loader #(
    parameter int DEPTH = 256,
    parameter int CNT_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        im_we_o,
    output logic [31:0] im_addr_o,
    output logic [31:0] im_data_o,
    output logic        cpu_rst_o,
    output logic        done_o,
    output logic        err_o
);

    // One extra bit so a word index equal to DEPTH is representable.
    localparam int IDX_W = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         bidx_q, bidx_d;
    logic [23:0]        asm_q, asm_d;
    logic               byte_ready_q, byte_ready_d;
    logic               im_we_q, im_we_d;
    logic [31:0]        im_addr_q, im_addr_d;
    logic [31:0]        im_data_q, im_data_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               accept;
    logic [CNT_W-1:0]   hdr_cnt;
    logic [IDX_W-1:0]   idx_inc;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        bidx_d    = bidx_q;
        asm_d     = asm_q;
        im_addr_d = im_addr_q;
        im_data_d = im_data_q;

        accept  = byte_valid_i && byte_ready_q;
        hdr_cnt = CNT_W'({cnt_q[CNT_W-1:CNT_W-8], byte_i});
        idx_inc = idx_q + IDX_W'(1);

        case (state_q)
            S_HDR0: begin
                if (accept) begin
                    cnt_d   = CNT_W'({byte_i, 8'h00});
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                if (accept) begin
                    cnt_d  = hdr_cnt;
                    idx_d  = '0;
                    bidx_d = '0;
                    if (hdr_cnt == '0) begin
                        state_d = S_DONE;
                    end else if (32'(hdr_cnt) > 32'(DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    asm_d = {asm_q[15:0], byte_i};
                    if (bidx_q == 2'd3) begin
                        bidx_d    = '0;
                        im_addr_d = 32'(idx_q) << 2;
                        im_data_d = {asm_q, byte_i};
                        state_d   = S_WRITE;
                    end else begin
                        bidx_d = bidx_q + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                idx_d = idx_inc;
                if (CNT_W'(idx_inc) == cnt_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DONE, S_ERR: begin
                if (start_i) begin
                    idx_d   = '0;
                    bidx_d  = '0;
                    cnt_d   = '0;
                    state_d = S_HDR0;
                end
            end
            default: state_d = S_HDR0;
        endcase

        byte_ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA);
        im_we_d      = (state_d == S_WRITE);
        done_d       = (state_d == S_DONE);
        err_d        = (state_d == S_ERR);
        cpu_rst_d    = (state_d == S_DONE);
    end

    // State, datapath and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_HDR0;
            cnt_q        <= '0;
            idx_q        <= '0;
            bidx_q       <= '0;
            asm_q        <= '0;
            byte_ready_q <= 1'b1;
            im_we_q      <= 1'b0;
            im_addr_q    <= '0;
            im_data_q    <= '0;
            cpu_rst_q    <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            bidx_q       <= bidx_d;
            asm_q        <= asm_d;
            byte_ready_q <= byte_ready_d;
            im_we_q      <= im_we_d;
            im_addr_q    <= im_addr_d;
            im_data_q    <= im_data_d;
            cpu_rst_q    <= cpu_rst_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign byte_ready_o = byte_ready_q;
    assign im_we_o      = im_we_q;
    assign im_addr_o    = im_addr_q;
    assign im_data_o    = im_data_q;
    assign cpu_rst_o    = cpu_rst_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed scenarios plus randomized
// programs compared against a byte-stream-level model of the loaded memory.
module tb_instr_loader;

    localparam int DEPTH = 256;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  byte_i = 8'h00;
    logic        byte_valid_i = 1'b0;
    logic        byte_ready_o;
    logic        im_we_o;
    logic [31:0] im_addr_o;
    logic [31:0] im_data_o;
    logic        cpu_rst_o;
    logic        done_o;
    logic        err_o;

    instr_loader #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .im_we_o      (im_we_o),
        .im_addr_o    (im_addr_o),
        .im_data_o    (im_data_o),
        .cpu_rst_o    (cpu_rst_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    int tests_run = 0;
    int tests_failed = 0;
    int cycle = 0;

    // Count rising edges so events can be placed relative to each other.
    always @(posedge clk_i) cycle <= cycle + 1;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          ready_viol = 0;
    int          cpu_viol = 0;
    int          done_rise_cyc = -1;
    logic        done_prev = 1'b0;
    logic [7:0]  tx_q[$];
    int          last_acc_cyc = -1;

    // Observe memory writes and protocol properties on the falling edge.
    always @(negedge clk_i) begin
        if (im_we_o) begin
            wr_addr_q.push_back(im_addr_o);
            wr_data_q.push_back(im_data_o);
            wr_cyc_q.push_back(cycle);
            if (byte_ready_o) ready_viol++;
        end
        if (cpu_rst_o && !done_o) cpu_viol++;
        if (done_o && !done_prev) done_rise_cyc = cycle;
        done_prev = done_o;
    end

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        ready_viol = 0;
        cpu_viol = 0;
        done_rise_cyc = -1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        start_i = 1'b0;
        byte_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        clear_mon();
    endtask

    // Push tx_q through the handshake; gaps are random (gap_pct) and/or fixed after each byte.
    task automatic drive_stream(input int gap_pct, input int fixed_gap);
        int idx = 0;
        int gapleft = 0;
        int budget = 20 * tx_q.size() + 50;
        while (idx < tx_q.size() && budget > 0) begin
            @(negedge clk_i);
            budget--;
            if (gapleft > 0) begin
                byte_valid_i = 1'b0;
                gapleft--;
            end else if (gap_pct > 0 && ($urandom % 100) < gap_pct) begin
                byte_valid_i = 1'b0;
            end else begin
                byte_valid_i = 1'b1;
                byte_i = tx_q[idx];
                if (byte_ready_o) begin
                    idx++;
                    last_acc_cyc = cycle;
                    gapleft = fixed_gap;
                end
            end
        end
        @(negedge clk_i);
        byte_valid_i = 1'b0;
        #1;
        tests_run++;
        if (idx !== tx_q.size()) begin
            tests_failed++;
            $display("[TB] FAIL stream_accept: accepted %0d bytes, required %0d", idx, tx_q.size());
        end
    endtask

    task automatic wait_finish(input int limit);
        int n = 0;
        while (!(done_o || err_o) && n < limit) begin
            @(negedge clk_i);
            n++;
        end
        #1;
        tests_run++;
        if (!(done_o || err_o)) begin
            tests_failed++;
            $display("[TB] FAIL finish_timeout: done_o=%0b err_o=%0b after %0d cycles", done_o, err_o, n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        tests_run += 7;
        if (byte_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready: got %0b want 1", byte_ready_o); end
        if (im_we_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_we: got %0b want 0", im_we_o); end
        if (im_addr_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_addr: got %h want 0", im_addr_o); end
        if (im_data_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_data: got %h want 0", im_data_o); end
        if (cpu_rst_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_cpu_rst: got %0b want 0", cpu_rst_o); end
        if (done_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %0b want 0", done_o); end
        if (err_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %0b want 0", err_o); end
        do_reset();
    endtask

    task automatic test_basic();
        int stray_ready = 0;
        do_reset();
        tx_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        drive_stream(0, 0);
        @(negedge clk_i);
        #1;
        tests_run++;
        if (wr_addr_q.size() !== 2) begin
            tests_failed++;
            $display("[TB] FAIL basic_write_count: got %0d want 2", wr_addr_q.size());
        end else begin
            tests_run += 5;
            if (wr_addr_q[0] !== 32'h0) begin tests_failed++; $display("[TB] FAIL basic_addr0: got %h want 0", wr_addr_q[0]); end
            if (wr_data_q[0] !== 32'h20080005) begin tests_failed++; $display("[TB] FAIL basic_data0: got %h want 20080005", wr_data_q[0]); end
            if (wr_addr_q[1] !== 32'h4) begin tests_failed++; $display("[TB] FAIL basic_addr1: got %h want 4", wr_addr_q[1]); end
            if (wr_data_q[1] !== 32'h01095020) begin tests_failed++; $display("[TB] FAIL basic_data1: got %h want 01095020", wr_data_q[1]); end
            if (done_rise_cyc !== wr_cyc_q[1] + 1) begin tests_failed++; $display("[TB] FAIL basic_done_timing: done at %0d want %0d", done_rise_cyc, wr_cyc_q[1] + 1); end
        end
        tests_run += 4;
        if (ready_viol !== 0) begin tests_failed++; $display("[TB] FAIL basic_ready_in_write: %0d writes with ready high, want 0", ready_viol); end
        if (cpu_viol !== 0) begin tests_failed++; $display("[TB] FAIL basic_cpu_early: %0d cycles released before done, want 0", cpu_viol); end
        if (done_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_done: got %0b want 1", done_o); end
        if (cpu_rst_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_cpu_rst: got %0b want 1", cpu_rst_o); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            byte_valid_i = 1'b1;
            byte_i = 8'($urandom);
            if (byte_ready_o) stray_ready++;
        end
        @(negedge clk_i);
        byte_valid_i = 1'b0;
        #1;
        tests_run += 2;
        if (stray_ready !== 0) begin tests_failed++; $display("[TB] FAIL basic_extra_ready: ready high %0d cycles, want 0", stray_ready); end
        if (wr_addr_q.size() !== 2) begin tests_failed++; $display("[TB] FAIL basic_extra_writes: got %0d writes want 2", wr_addr_q.size()); end
    endtask

    task automatic test_empty();
        do_reset();
        tx_q = '{8'h00, 8'h00};
        drive_stream(0, 0);
        tests_run += 5;
        if (done_rise_cyc !== last_acc_cyc + 1) begin tests_failed++; $display("[TB] FAIL empty_done_timing: done at %0d want %0d", done_rise_cyc, last_acc_cyc + 1); end
        if (done_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL empty_done: got %0b want 1", done_o); end
        if (cpu_rst_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL empty_cpu_rst: got %0b want 1", cpu_rst_o); end
        if (byte_ready_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL empty_ready: got %0b want 0", byte_ready_o); end
        if (wr_addr_q.size() !== 0) begin tests_failed++; $display("[TB] FAIL empty_writes: got %0d want 0", wr_addr_q.size()); end
    endtask

    task automatic test_oversize();
        do_reset();
        tx_q = '{8'h01, 8'h01};
        drive_stream(0, 0);
        repeat (3) @(negedge clk_i);
        #1;
        tests_run += 5;
        if (err_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL over_err: got %0b want 1", err_o); end
        if (cpu_rst_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL over_cpu_rst: got %0b want 0", cpu_rst_o); end
        if (byte_ready_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL over_ready: got %0b want 0", byte_ready_o); end
        if (done_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL over_done: got %0b want 0", done_o); end
        if (wr_addr_q.size() !== 0) begin tests_failed++; $display("[TB] FAIL over_writes: got %0d want 0", wr_addr_q.size()); end
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        tests_run += 3;
        if (err_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL restart_err: got %0b want 0", err_o); end
        if (byte_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL restart_ready: got %0b want 1", byte_ready_o); end
        if (cpu_rst_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL restart_cpu_rst: got %0b want 0", cpu_rst_o); end
    endtask

    task automatic test_stall();
        do_reset();
        tx_q = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        drive_stream(0, 3);
        wait_finish(20);
        tests_run += 2;
        if (done_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_done: got %0b want 1", done_o); end
        if (wr_addr_q.size() !== 1) begin
            tests_failed++;
            $display("[TB] FAIL stall_write_count: got %0d want 1", wr_addr_q.size());
        end else begin
            tests_run += 2;
            if (wr_addr_q[0] !== 32'h0) begin tests_failed++; $display("[TB] FAIL stall_addr: got %h want 0", wr_addr_q[0]); end
            if (wr_data_q[0] !== 32'hAABBCCDD) begin tests_failed++; $display("[TB] FAIL stall_data: got %h want AABBCCDD", wr_data_q[0]); end
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        tx_q = '{8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        drive_stream(0, 0);
        #2;
        rst_i = 1'b0;
        #1;
        tests_run += 7;
        if (byte_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_ready: got %0b want 1", byte_ready_o); end
        if (im_we_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_we: got %0b want 0", im_we_o); end
        if (im_addr_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL mid_addr: got %h want 0", im_addr_o); end
        if (im_data_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL mid_data: got %h want 0", im_data_o); end
        if (cpu_rst_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_cpu_rst: got %0b want 0", cpu_rst_o); end
        if (done_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_done: got %0b want 0", done_o); end
        if (err_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_err: got %0b want 0", err_o); end
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        clear_mon();
        tx_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        drive_stream(0, 0);
        wait_finish(20);
        tests_run++;
        if (wr_addr_q.size() !== 1) begin
            tests_failed++;
            $display("[TB] FAIL mid_reload_count: got %0d want 1", wr_addr_q.size());
        end else begin
            tests_run += 2;
            if (wr_addr_q[0] !== 32'h0) begin tests_failed++; $display("[TB] FAIL mid_reload_addr: got %h want 0", wr_addr_q[0]); end
            if (wr_data_q[0] !== 32'h11223344) begin tests_failed++; $display("[TB] FAIL mid_reload_data: got %h want 11223344", wr_data_q[0]); end
        end
    endtask

    // Random programs, each after a restart from DONE; expected memory comes from the byte stream.
    task automatic test_random_programs();
        do_reset();
        for (int it = 0; it < 5; it++) begin
            int n = $urandom_range(1, 12);
            if (it > 0) begin
                @(negedge clk_i);
                start_i = 1'b1;
                @(negedge clk_i);
                start_i = 1'b0;
                #1;
                clear_mon();
                tests_run += 2;
                if (done_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL rnd_restart_done: got %0b want 0", done_o); end
                if (byte_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL rnd_restart_ready: got %0b want 1", byte_ready_o); end
            end
            tx_q.delete();
            tx_q.push_back(8'(n >> 8));
            tx_q.push_back(8'(n));
            for (int b = 0; b < 4 * n; b++) tx_q.push_back(8'($urandom));
            drive_stream(30, 0);
            wait_finish(40);
            tests_run += 3;
            if (ready_viol !== 0) begin tests_failed++; $display("[TB] FAIL rnd_ready_in_write: %0d", ready_viol); end
            if (cpu_viol !== 0) begin tests_failed++; $display("[TB] FAIL rnd_cpu_early: %0d", cpu_viol); end
            if (cpu_rst_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL rnd_cpu_rst: got %0b want 1", cpu_rst_o); end
            tests_run++;
            if (wr_addr_q.size() !== n) begin
                tests_failed++;
                $display("[TB] FAIL rnd_write_count: got %0d want %0d", wr_addr_q.size(), n);
            end else begin
                tests_run++;
                if (done_rise_cyc !== wr_cyc_q[n-1] + 1) begin tests_failed++; $display("[TB] FAIL rnd_done_timing: got %0d want %0d", done_rise_cyc, wr_cyc_q[n-1] + 1); end
                for (int w = 0; w < n; w++) begin
                    logic [31:0] exp_data;
                    exp_data = {tx_q[2+4*w], tx_q[3+4*w], tx_q[4+4*w], tx_q[5+4*w]};
                    tests_run += 2;
                    if (wr_addr_q[w] !== 32'(4 * w)) begin tests_failed++; $display("[TB] FAIL rnd_addr[%0d]: got %h want %h", w, wr_addr_q[w], 32'(4 * w)); end
                    if (wr_data_q[w] !== exp_data) begin tests_failed++; $display("[TB] FAIL rnd_data[%0d]: got %h want %h", w, wr_data_q[w], exp_data); end
                end
            end
        end
    endtask

    task automatic test_full_capacity();
        do_reset();
        tx_q.delete();
        tx_q.push_back(8'(DEPTH >> 8));
        tx_q.push_back(8'(DEPTH));
        for (int b = 0; b < 4 * DEPTH; b++) tx_q.push_back(8'($urandom));
        drive_stream(10, 0);
        wait_finish(40);
        repeat (10) @(negedge clk_i);
        #1;
        tests_run += 3;
        if (done_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_done: got %0b want 1", done_o); end
        if (err_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_err: got %0b want 0", err_o); end
        if (wr_addr_q.size() !== DEPTH) begin
            tests_failed++;
            $display("[TB] FAIL full_write_count: got %0d want %0d", wr_addr_q.size(), DEPTH);
        end else begin
            for (int w = 0; w < DEPTH; w++) begin
                logic [31:0] exp_data;
                exp_data = {tx_q[2+4*w], tx_q[3+4*w], tx_q[4+4*w], tx_q[5+4*w]};
                tests_run += 2;
                if (wr_addr_q[w] !== 32'(4 * w)) begin tests_failed++; $display("[TB] FAIL full_addr[%0d]: got %h want %h", w, wr_addr_q[w], 32'(4 * w)); end
                if (wr_data_q[w] !== exp_data) begin tests_failed++; $display("[TB] FAIL full_data[%0d]: got %h want %h", w, wr_data_q[w], exp_data); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_oversize();
        test_stall();
        test_reset_mid_load();
        test_random_programs();
        test_full_capacity();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Boot-time loader upstream of the single-cycle CPU's instruction memory.
- Accepts a byte stream over a valid/ready handshake: a 16-bit word-count header, then the program.
- Assembles big-endian 32-bit instructions, writes them into instruction memory from word 0 upward, and holds the CPU in reset until the load finishes.
- On a header error, raises an error flag and keeps the CPU in reset.

Parameters:
- DEPTH, 256, instruction memory capacity in 32-bit words; the largest legal header count.
- CNT_W, 16, header word-count width. Fixed at two bytes.

Ports:
- clk_i  in  1  system clock, rising-edge.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  one-cycle pulse; restarts a load from DONE or ERR.
- byte_i  in  8  stream data byte.
- byte_valid_i  in  1  byte_i is valid.
- byte_ready_o  out  1  loader can accept a byte.
- im_we_o  out  1  instruction memory write strobe, one cycle per word.
- im_addr_o  out  32  byte address of the word being written; bits [1:0] are always 0.
- im_data_o  out  32  assembled instruction word.
- cpu_rst_o  out  1  active-low reset to the CPU: 0 holds the CPU, 1 releases it.
- done_o  out  1  load complete.
- err_o  out  1  header count exceeds DEPTH.

Behaviour:
- Byte transfer: a byte transfers on a rising edge where byte_valid_i=1 and byte_ready_o=1. byte_i is ignored otherwise.
- All outputs are registered.
- Reset (rst_i=0, takes effect immediately, also mid-load):
  - state=HDR0; byte_ready_o=1; im_we_o=0; im_addr_o=0; im_data_o=0; cpu_rst_o=0; done_o=0; err_o=0.
  - Word index, byte index and count registers clear to 0.
- States:
  - HDR0: accept the count high byte -> HDR1.
  - HDR1: accept the count low byte. Then:
    - count=0 -> DONE.
    - count>DEPTH -> ERR.
    - otherwise -> DATA with word index=0 and byte index=0.
  - DATA: byte_ready_o=1. Each accepted byte shifts into the assembly register MSB-first, so the first byte lands in bits [31:24]. On acceptance of the 4th byte -> WRITE.
  - WRITE: lasts exactly 1 cycle.
    - byte_ready_o=0; im_we_o=1; im_addr_o=word_index<<2; im_data_o=assembled word.
    - The word index then increments.
    - If the incremented index equals count -> DONE, else -> DATA.
  - DONE: byte_ready_o=0; done_o=1; cpu_rst_o=1. Incoming bytes are not accepted.
  - ERR: byte_ready_o=0; err_o=1; cpu_rst_o=0.
- Latency:
  - im_we_o is high in the cycle immediately after the edge that accepts the 4th byte of a word.
  - The earliest next byte transfer is on the edge that ends that WRITE cycle's successor DATA cycle. There is therefore a 1-cycle bubble per word.
  - done_o and cpu_rst_o rise in the cycle after the final WRITE cycle.
- im_we_o is 0 in every state except WRITE. In other states im_addr_o and im_data_o hold their last values.
- Gaps in byte_valid_i within a word are allowed; assembly resumes without loss.
- Restart: start_i=1 in DONE or ERR -> next cycle:
  - state=HDR0; byte_ready_o=1; done_o=0; err_o=0; cpu_rst_o=0.
  - Indices clear. Instruction memory contents are not cleared.
  - start_i is ignored in all other states.
- Boundary cases:
  - count=DEPTH is legal and writes up to address (DEPTH-1)*4.
  - count=DEPTH+1 -> ERR.
  - Word index width is clog2(DEPTH)+1 so that reaching count=DEPTH does not wrap.
- Reset asserted during WRITE: the write strobe drops asynchronously. Whether that word was written is unspecified; the CPU stays held in reset.

Test Plan:
- Basic load: reset, then stream 00 02 | 20 08 00 05 | 01 09 50 20 with byte_valid_i held high. Required:
  - im_we_o pulses twice: addr 0x0 with data 0x20080005, then addr 0x4 with data 0x01095020.
  - byte_ready_o=0 during each WRITE cycle.
  - done_o=1 and cpu_rst_o=1 the cycle after the 2nd write.
  - No im_we_o after that; extra bytes see byte_ready_o=0.
- Empty program: stream 00 00 -> no im_we_o; the cycle after the 2nd byte, done_o=1 and cpu_rst_o=1.
- Oversize header (DEPTH=256): stream 01 01 -> err_o=1, cpu_rst_o=0, byte_ready_o=0, no writes. Then a start_i pulse -> err_o=0 and byte_ready_o=1 next cycle.
- Stalled stream: header 00 01, then bytes AA BB CC DD with byte_valid_i low for 3 cycles between each -> a single write of 0xAABBCCDD at addr 0x0; done_o=1 afterwards.
- Reset mid-load: count=4, after 6 data bytes drive rst_i=0 -> all outputs at reset values immediately. Reload 00 01 11 22 33 44 -> write of 0x11223344 at addr 0x0.
- Full capacity (DEPTH=4): header 00 04 with 16 bytes -> writes at 0x0, 0x4, 0x8, 0xC, then done_o=1 with no index wrap and no 5th write.
